// File: rtl/bus_drvr_fifo.sv
// bus_drvr_fifo: per-terminal show-ahead source FIFO feeding one bus driver slot.
// The agent enqueues with wr_en/wr_data; the downstream bus drains through
// pndng/pop/D_pop, with sticky overflow/underflow flags recording lost traffic.
//
// Handshake: pndng acts as "valid" and pop as "ready/consume". The head entry
// is stable on D_pop whenever pndng is high, and a pop is taken only on a
// rising edge where both pop and pndng are high. On the write side, full acts
// as "not ready": a write while full is taken only if a pop is taken on the
// same edge; otherwise it is dropped and overflow is set. Every output is
// driven from registered state only, with no combinational path from pop or
// wr_en.
module bus_drvr_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       full,
  output logic                       pndng,
  input  logic                       pop,
  output logic [pckg_sz-1:0]         D_pop,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth+1);

  logic [pckg_sz-1:0] mem [depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic [cw-1:0]      cnt;
  logic               wr_acc;
  logic               pop_acc;

  // Status and show-ahead head, all taken from registered state.
  always_comb begin
    pndng = (cnt != '0);
    full  = (cnt == cw'(depth));
    count = cnt;
    D_pop = pndng ? mem[rd_ptr] : '0;
  end

  // Accept decisions. A pop while full always frees a slot, so a write is
  // taken alongside it. On an empty FIFO the pop is ignored even if a write
  // arrives on the same edge: the new entry is never bypassed to D_pop.
  always_comb begin
    wr_acc  = wr_en && (!full || pop);
    pop_acc = pop && pndng;
  end

  // Storage array; contents are not reset, validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy counter and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)  wr_ptr <= wr_ptr + aw'(1);
      if (pop_acc) rd_ptr <= rd_ptr + aw'(1);
      case ({wr_acc, pop_acc})
        2'b10:   cnt <= cnt + cw'(1);
        2'b01:   cnt <= cnt - cw'(1);
        default: cnt <= cnt;
      endcase
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (pop && !pndng)    underflow <= 1'b1;
    end
  end

endmodule

// File: doc/bus_drvr_fifo.md
# bus_drvr_fifo

Per-terminal source FIFO that sits directly upstream of the multi-bus DUT, one instance per `[bit][drvr]` slot. The test agent writes packages in; the DUT drains them through the `pndng`/`pop`/`D_pop` handshake. Packages are presented show-ahead: the head entry is valid on `D_pop` whenever `pndng` is high. Overflow and underflow are recorded in sticky flags so the scoreboard can flag dropped traffic.

## Interface
- `pckg_sz`, default 16: package width in bits; must be ≥1.
- `depth`, default 8: FIFO entries; must be a power of two, ≥2.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserted when 0.
- `wr_en` input 1: agent write request.
- `wr_data` input pckg_sz: package to enqueue.
- `full` output 1: FIFO holds `depth` entries.
- `pndng` output 1: FIFO is non-empty; the head is valid on `D_pop`.
- `pop` input 1: DUT consumes the head entry.
- `D_pop` output pckg_sz: head entry; 0 when empty.
- `count` output $clog2(depth+1): current occupancy.
- `overflow` output 1: sticky; a write was dropped.
- `underflow` output 1: sticky; a pop arrived while empty.

## Operation
- **Storage**
  - `depth` × `pckg_sz` register array.
  - Read and write pointers are `$clog2(depth)` bits and wrap naturally modulo `depth`.
  - `count` is an explicit counter, not derived from the pointers.
- **Derived outputs** (combinational from state)
  - `pndng` = (`count` != 0).
  - `full` = (`count` == `depth`).
  - `D_pop` = `mem[rd_ptr]` when `pndng`, else 0.
- **Accept rules**, evaluated on state at the clock edge:
  - Write accepted when `wr_en` && (!`full` || `pop`).
  - Pop accepted when `pop` && `pndng`.
- **Simultaneous write and pop**
  - Full: both accepted; `count` unchanged; no overflow.
  - Empty: write accepted; pop ignored; `underflow` set; `count` becomes 1. Show-ahead never bypasses the array.
  - Otherwise both accepted; `count` unchanged.
- **Write only, full** → data dropped, pointers unchanged, `overflow` set.
- **Pop only, empty** → no state change except `underflow` set.
- **Sticky flags** `overflow` and `underflow` clear only on reset.
- **Reset**
  - All pointers, `count`, `overflow` and `underflow` go to 0. Outputs become `full`=0, `pndng`=0, `D_pop`=0, `count`=0.
  - Array contents need not be cleared.
  - Reset mid-operation discards all queued packages immediately, asynchronously, without waiting for a clock edge.
  - The first write is accepted on the first rising edge with `reset`=1.

## Timing
- **Write-to-visibility latency:** 1 cycle. A write accepted at edge N gives `pndng`=1 and valid `D_pop` after edge N. It is poppable at edge N+1.
- **Pop:** the DUT samples `D_pop` in the same cycle it asserts `pop`. After the edge, `D_pop` shows the next entry, or 0 if the FIFO is now empty.
- **Throughput:** one write and one pop per cycle sustained, with no bubbles.
- **Combinational paths:** `full`, `pndng`, `D_pop` and `count` depend on registered state only. There is no combinational path from `pop` or `wr_en` to any output.

## Test plan
- **Reset and single package**
  - Stimulus: reset low for 3 cycles, then release. Write 0xA5A5 at edge 1.
  - Required: all outputs 0 during reset. After edge 1, `pndng`=1, `D_pop`=0xA5A5, `count`=1. Pop at edge 2 → `pndng`=0, `D_pop`=0.
- **Fill and overflow** (depth 8)
  - Stimulus: write 0x0001–0x0008 on consecutive edges, then write 0x0009.
  - Required: `full`=1 after 8 writes. 0x0009 dropped, `overflow`=1, `count`=8. Draining yields 0x0001–0x0008 in order.
- **Full with simultaneous write and pop**
  - Stimulus: FIFO full with 0x0001–0x0008; assert `wr_en` with 0x0009 and `pop` together.
  - Required: `count`=8, `overflow`=0, new head 0x0002. Full drain ends with 0x0009.
- **Empty corner**
  - Stimulus: pop while empty, then write 0x1234 and pop in the same cycle.
  - Required: `underflow`=1. After the edge, `count`=1 and `D_pop`=0x1234.
- **Wrap-around**
  - Stimulus: 20 cycles of continuous write and pop with an incrementing pattern, starting from `count`=3.
  - Required: `count` stays 3 throughout. Popped order matches written order across multiple pointer wraps.
- **Reset mid-operation**
  - Stimulus: FIFO holds 5 entries with `overflow` set; assert `reset` between edges.
  - Required: `pndng`, `count` and `overflow` drop to 0 immediately, before the next edge. After release, a write of 0x00FF appears as the sole entry.
